// File: rtl/etpu_pkg.sv
// rtl/etpu_pkg.sv - shared constants and FSM encoding for the edu_tpu Wishbone host
package etpu_pkg;

    localparam logic [31:0] BASE_ADDRESS_DEF  = 32'h3000_0000;
    localparam int          N_WEIGHT          = 3;
    localparam int          N_INPUT           = 6;
    localparam int          N_RESULT          = 5;
    localparam int          N_JOB             = N_WEIGHT + N_INPUT;
    localparam int          SETTLE_CYCLES_DEF = 40;
`ifdef WB_TIMEOUT_EN
    localparam int          TIMEOUT           = 255;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_SETTLE = 3'd3,
        S_RD_REQ = 3'd4,
        S_RD_GAP = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/edu_tpu_wb_host_if.sv
// rtl/edu_tpu_wb_host_if.sv - Wishbone initiator bus bundle
// master: drives cyc/stb/we/sel/adr/dat_o, receives ack/dat_i.
// slave : the responder view of the same wires.
interface edu_tpu_wb_host_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_single_xact.sv
// rtl/wb_single_xact.sv - one Wishbone request/ack/gap cycle with optional ack timeout
// Optional feature macro: WB_TIMEOUT_EN (ack timeout counter).
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  req             caller is in a request state: drive the bus
//  gap             caller is in a gap state: watch ack for the idle rule
//  req_we          write (1) or read (0) request
//  req_wdata       write data, held stable by the caller for the whole request
//  accepted        ack sampled while requesting (caller leaves request on this edge)
//  first_gap       first cycle after the accepting edge (read capture point)
//  gap_done        gap rule satisfied, caller may issue the next request
//  timeout         request went unanswered for TIMEOUT cycles
//  wb              Wishbone master view
module wb_single_xact
    import etpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = BASE_ADDRESS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     gap,
    input  logic                     req_we,
    input  logic [31:0]              req_wdata,
    output logic                     accepted,
    output logic                     first_gap,
    output logic                     gap_done,
    output logic                     timeout,
    edu_tpu_wb_host_if.master        wb
);

    logic gap_low_q;
    logic acc_q;

    assign wb.wbm_cyc_o = req;
    assign wb.wbm_stb_o = req;
    assign wb.wbm_we_o  = req & req_we;
    assign wb.wbm_sel_o = req ? 4'hF : 4'h0;
    assign wb.wbm_adr_o = req ? BASE_ADDRESS : 32'h0;
    assign wb.wbm_dat_o = (req && req_we) ? req_wdata : 32'h0;

    assign accepted  = req & wb.wbm_ack_i;
    assign first_gap = gap & acc_q;
    // Responder ack is registered, so it can still be high in the first gap
    // cycle; require one low sample and then one more cycle before releasing.
    assign gap_done  = gap & ~wb.wbm_ack_i & gap_low_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_low_q <= 1'b0;
            acc_q     <= 1'b0;
        end else begin
            gap_low_q <= gap & ~wb.wbm_ack_i;
            acc_q     <= accepted;
        end
    end

`ifdef WB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !req || wb.wbm_ack_i) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    assign timeout = req & ~wb.wbm_ack_i & (tmo_cnt_q == 8'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/edu_tpu_wb_host.sv
// rtl/edu_tpu_wb_host.sv - Wishbone host that runs one edu_tpu job (9 writes, settle, 5 reads)
// Optional feature macro: WB_TIMEOUT_EN (per-transaction ack timeout, sets sticky error).
// Ports:
//  caravel_wb_clk_i/caravel_wb_rst_i  clock, synchronous active-high reset
//  job_we/job_addr/job_wdata          job buffer write port (0..2 weights, 3..8 inputs)
//  start                              launch a job (accepted only in IDLE)
//  busy/done/error                    job status
//  res_valid/res_idx/res_data         one pulse per captured result word
//  wb                                 Wishbone master bus
module edu_tpu_wb_host
    import etpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS  = BASE_ADDRESS_DEF,
    parameter int          SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              caravel_wb_clk_i,
    input  logic              caravel_wb_rst_i,
    input  logic              job_we,
    input  logic [3:0]        job_addr,
    input  logic [31:0]       job_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              res_valid,
    output logic [2:0]        res_idx,
    output logic [31:0]       res_data,
    edu_tpu_wb_host_if.master wb
);

    localparam int         SW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0] K_WR_END  = 4'(N_JOB);
    localparam logic [3:0] K_RD_LAST = 4'(N_RESULT - 1);

    state_t          state_q, state_d;
    logic [3:0]      k_q;
    logic [SW-1:0]   settle_q;
    logic [31:0]     dat_q;
    logic            error_q;
    logic            res_valid_q;
    logic [2:0]      res_idx_q;
    logic [31:0]     res_data_q;
    logic [31:0]     job_mem [N_JOB];

    logic req, gap, accepted, first_gap, gap_done, xact_tmo;

    // Job buffer is deliberately outside reset so a preloaded job survives it.
    always_ff @(posedge caravel_wb_clk_i) begin
        if (job_we && (job_addr < K_WR_END)) begin
            job_mem[job_addr] <= job_wdata;
        end
    end

    assign req = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign gap = (state_q == S_WR_GAP) || (state_q == S_RD_GAP);

    wb_single_xact #(
        .BASE_ADDRESS (BASE_ADDRESS)
    ) u_xact (
        .clk       (caravel_wb_clk_i),
        .rst       (caravel_wb_rst_i),
        .req       (req),
        .gap       (gap),
        .req_we    (state_q == S_WR_REQ),
        .req_wdata (dat_q),
        .accepted  (accepted),
        .first_gap (first_gap),
        .gap_done  (gap_done),
        .timeout   (xact_tmo),
        .wb        (wb)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_WR_REQ;
            S_WR_REQ: begin
                if (xact_tmo)      state_d = S_ERR;
                else if (accepted) state_d = S_WR_GAP;
            end
            S_WR_GAP: if (gap_done) state_d = (k_q < K_WR_END) ? S_WR_REQ : S_SETTLE;
            S_SETTLE: if (settle_q == '0) state_d = S_RD_REQ;
            S_RD_REQ: begin
                if (xact_tmo)      state_d = S_ERR;
                else if (accepted) state_d = S_RD_GAP;
            end
            S_RD_GAP: if (gap_done) state_d = (k_q < K_RD_LAST) ? S_RD_REQ : S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge caravel_wb_clk_i) begin
        if (caravel_wb_rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= 4'd0;
            settle_q    <= '0;
            dat_q       <= 32'h0;
            error_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= 3'd0;
            res_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_q     <= 4'd0;
                        error_q <= 1'b0;
                        dat_q   <= job_mem[0];
                    end
                end
                S_WR_REQ: begin
                    if (xact_tmo)      error_q <= 1'b1;
                    else if (accepted) k_q     <= k_q + 4'd1;
                end
                S_WR_GAP: begin
                    // Write data is latched at request start so job buffer
                    // updates never disturb a transaction already on the bus.
                    if (gap_done) begin
                        if (k_q < K_WR_END) dat_q    <= job_mem[k_q];
                        else                settle_q <= SW'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: begin
                    settle_q <= settle_q - SW'(1);
                    if (settle_q == '0) k_q <= 4'd0;
                end
                S_RD_REQ: begin
                    if (xact_tmo) error_q <= 1'b1;
                end
                S_RD_GAP: begin
                    if (first_gap) begin
                        res_valid_q <= 1'b1;
                        res_idx_q   <= k_q[2:0];
                        res_data_q  <= wb.wbm_dat_i;
                    end
                    if (gap_done && (k_q < K_RD_LAST)) k_q <= k_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_edu_tpu_wb_host.sv
// tb/tb_edu_tpu_wb_host.sv - self-checking bench for edu_tpu_wb_host
module tb_edu_tpu_wb_host;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_we = 1'b0;
    logic [3:0]  job_addr = 4'd0;
    logic [31:0] job_wdata = 32'h0;
    logic        start = 1'b0;
    logic        busy, done, error, res_valid;
    logic [2:0]  res_idx;
    logic [31:0] res_data;

    always #5 clk = ~clk;

    edu_tpu_wb_host_if wb();

    edu_tpu_wb_host dut (
        .caravel_wb_clk_i (clk),
        .caravel_wb_rst_i (rst),
        .job_we           (job_we),
        .job_addr         (job_addr),
        .job_wdata        (job_wdata),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .res_valid        (res_valid),
        .res_idx          (res_idx),
        .res_data         (res_data),
        .wb               (wb)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] job_vals [9];
    logic [31:0] exp_wr[$], obs_wr[$], exp_dat[$], obs_dat[$];
    logic [2:0]  exp_idx[$], obs_idx[$];

    int  ack_delay = 0;
    bit  never_ack = 1'b0;
    int  wait_cnt = 0;
    int  acc_job = 0, wr_in_job = 0, rd_n = 0, order_err = 0;
    int  cyc_n = 0, rd_ack_cyc = -100, lat_err = 0, bus_err = 0, stab_err = 0;
    int  done_cnt = 0, idle_cnt = 0, idle_before_rd = -1;
    bit  stb_prev = 1'b0;
    logic [31:0] held_dat = 32'h0;

    // Registered responder: raises ack ack_delay+1 edges after stb, returns 0xA0+n on read n.
    always @(posedge clk) begin
        if (rst) begin
            wb.wbm_ack_i <= 1'b0;
            wb.wbm_dat_i <= 32'h0;
            wait_cnt = 0;
        end else if (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i && !never_ack) begin
            if (wait_cnt >= ack_delay) begin
                wb.wbm_ack_i <= 1'b1;
                wait_cnt = 0;
                acc_job++;
                if (wb.wbm_we_o) begin
                    obs_wr.push_back(wb.wbm_dat_o);
                    wr_in_job++;
                end else begin
                    if (wr_in_job != 9) order_err++;
                    wb.wbm_dat_i <= 32'hA0 + 32'(rd_n);
                    rd_n++;
                end
            end else begin
                wait_cnt++;
                wb.wbm_ack_i <= 1'b0;
            end
        end else begin
            wb.wbm_ack_i <= 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc_n++;
        if (done) done_cnt++;
        if (wb.wbm_stb_o) begin
            if (wb.wbm_sel_o !== 4'hF || wb.wbm_adr_o !== BASE || wb.wbm_cyc_o !== 1'b1) bus_err++;
            if (!stb_prev) begin
                held_dat = wb.wbm_dat_o;
                if (!wb.wbm_we_o && rd_n == 0) idle_before_rd = idle_cnt;
            end else if (wb.wbm_dat_o !== held_dat) begin
                stab_err++;
            end
            idle_cnt = 0;
            if (wb.wbm_ack_i && !wb.wbm_we_o) rd_ack_cyc = cyc_n;
        end else begin
            if (wb.wbm_cyc_o !== 1'b0 || wb.wbm_adr_o !== 32'h0) bus_err++;
            idle_cnt++;
        end
        stb_prev = wb.wbm_stb_o;
        if (res_valid) begin
            if (cyc_n != rd_ack_cyc + 2) lat_err++;
            obs_idx.push_back(res_idx);
            obs_dat.push_back(res_data);
        end
    end

    task automatic load_job();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            job_we = 1'b1; job_addr = 4'(i); job_wdata = job_vals[i];
        end
        @(negedge clk); job_addr = 4'd9;  job_wdata = 32'hDEAD_BEEF;
        @(negedge clk); job_addr = 4'd15;
        @(negedge clk); job_we = 1'b0; job_addr = 4'd0;
    endtask

    task automatic begin_job();
        obs_wr.delete(); obs_idx.delete(); obs_dat.delete();
        exp_wr.delete(); exp_idx.delete(); exp_dat.delete();
        wr_in_job = 0; rd_n = 0; acc_job = 0; order_err = 0;
        lat_err = 0; bus_err = 0; stab_err = 0; idle_before_rd = -1;
        for (int i = 0; i < 9; i++) exp_wr.push_back(job_vals[i]);
        for (int n = 0; n < 5; n++) begin
            exp_idx.push_back(3'(n));
            exp_dat.push_back(32'hA0 + 32'(n));
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}); end
        checks++; if (wb.wbm_sel_o !== 4'h0 || wb.wbm_adr_o !== 32'h0 || wb.wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_bus: sel %h adr %h dat %h expected all 0", wb.wbm_sel_o, wb.wbm_adr_o, wb.wbm_dat_o); end
        checks++; if ({busy, done, error, res_valid} !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b expected 0000", {busy, done, error, res_valid}); end
        checks++; if (res_idx !== 3'd0 || res_data !== 32'h0) begin errors++; $display("FAIL reset_res: idx %0d data %h expected 0", res_idx, res_data); end
        rst = 1'b0;
        @(negedge clk);
        bus_err = 0; done_cnt = 0;
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] got;
        job_vals = '{32'h11, 32'h22, 32'h33, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        load_job();
        ack_delay = 0;
        begin_job();
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_seen: got %0d expected 1", ok); end
        checks++; if (obs_wr.size() != 9) begin errors++; $display("FAIL basic_wr_count: got %0d expected 9", obs_wr.size()); end
        for (int i = 0; i < 9; i++) begin
            got = (obs_wr.size() > 0) ? obs_wr.pop_front() : 32'hx;
            checks++; if (got !== exp_wr[i]) begin errors++; $display("FAIL basic_wr%0d: got %h expected %h", i, got, exp_wr[i]); end
        end
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (obs_idx.size() == 0) begin errors++; $display("FAIL basic_res%0d: got none expected idx %0d data %h", n, exp_idx[n], exp_dat[n]); end
            else begin
                if (obs_idx[0] !== exp_idx[n] || obs_dat[0] !== exp_dat[n]) begin
                    errors++; $display("FAIL basic_res%0d: got idx %0d data %h expected idx %0d data %h", n, obs_idx[0], obs_dat[0], exp_idx[n], exp_dat[n]);
                end
                void'(obs_idx.pop_front()); void'(obs_dat.pop_front());
            end
        end
        checks++; if (idle_before_rd != 42) begin errors++; $display("FAIL basic_settle_idle: got %0d expected 42", idle_before_rd); end
        checks++; if (lat_err != 0) begin errors++; $display("FAIL basic_capture_latency: got %0d late captures expected 0", lat_err); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL basic_order: got %0d early reads expected 0", order_err); end
        checks++; if (bus_err != 0) begin errors++; $display("FAIL basic_bus_idle: got %0d bad cycles expected 0", bus_err); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL basic_end: busy %b dones %0d expected busy 0 dones 1", busy, done_cnt); end
    endtask

    task automatic test_slow_ack();
        bit ok;
        logic [31:0] got;
        int d0;
        for (int i = 0; i < 9; i++) job_vals[i] = $urandom;
        load_job();
        ack_delay = 4;
        d0 = done_cnt;
        begin_job();
        // Rewrite word 0 while it is on the bus; the in-flight write must not change.
        @(negedge clk);
        job_we = 1'b1; job_addr = 4'd0; job_wdata = 32'h5A5A_0000;
        @(negedge clk);
        job_we = 1'b0;
        job_vals[0] = 32'h5A5A_0000;
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_done_seen: got %0d expected 1", ok); end
        checks++; if (acc_job != 14) begin errors++; $display("FAIL slow_accepts: got %0d expected 14", acc_job); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL slow_dat_stable: got %0d changes expected 0", stab_err); end
        for (int i = 0; i < 9; i++) begin
            got = (obs_wr.size() > 0) ? obs_wr.pop_front() : 32'hx;
            checks++; if (got !== exp_wr[i]) begin errors++; $display("FAIL slow_wr%0d: got %h expected %h", i, got, exp_wr[i]); end
        end
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (obs_dat.size() == 0) begin errors++; $display("FAIL slow_res%0d: got none expected %h", n, exp_dat[n]); end
            else begin
                if (obs_idx[0] !== exp_idx[n] || obs_dat[0] !== exp_dat[n]) begin
                    errors++; $display("FAIL slow_res%0d: got idx %0d data %h expected idx %0d data %h", n, obs_idx[0], obs_dat[0], exp_idx[n], exp_dat[n]);
                end
                void'(obs_idx.pop_front()); void'(obs_dat.pop_front());
            end
        end
        checks++; if (lat_err != 0) begin errors++; $display("FAIL slow_capture_latency: got %0d expected 0", lat_err); end
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL slow_done_count: got %0d expected %0d", done_cnt - d0, 1); end
    endtask

    task automatic test_reset_mid_job();
        bit ok, hit;
        int d0;
        logic [31:0] got;
        ack_delay = 0;
        d0 = done_cnt;
        begin_job();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wb.wbm_stb_o && !wb.wbm_ack_i && wr_in_job == 3) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_wr4: got %0d expected 1", hit); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({wb.wbm_cyc_o, wb.wbm_stb_o, busy, done} !== 4'b0000) begin errors++; $display("FAIL rstmid_idle: cyc/stb/busy/done got %b expected 0000", {wb.wbm_cyc_o, wb.wbm_stb_o, busy, done}); end
        rst = 1'b0;
        repeat (150) @(negedge clk);
        checks++; if (done_cnt != d0 || acc_job != 3) begin errors++; $display("FAIL rstmid_no_done: got dones %0d accepts %0d expected 0 and 3", done_cnt - d0, acc_job); end
        begin_job();
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_replay_done: got %0d expected 1", ok); end
        for (int i = 0; i < 9; i++) begin
            got = (obs_wr.size() > 0) ? obs_wr.pop_front() : 32'hx;
            checks++; if (got !== exp_wr[i]) begin errors++; $display("FAIL rstmid_wr%0d: got %h expected %h", i, got, exp_wr[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int d0;
        ack_delay = 1;
        d0 = done_cnt;
        begin_job();
        for (int p = 0; p < 5; p++) begin
            repeat (9) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(2000, ok);
        repeat (150) @(negedge clk);
        checks++; if (acc_job != 14) begin errors++; $display("FAIL busy_start_xacts: got %0d expected 14", acc_job); end
        checks++; if (done_cnt != d0 + 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_done: got dones %0d busy %b expected 1 and 0", done_cnt - d0, busy); end
    endtask

    task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
        int n_stb, d0;
        bit ok;
        ack_delay = 0;
        never_ack = 1'b1;
        d0 = done_cnt;
        begin_job();
        n_stb = 0;
        for (int i = 0; i < 400; i++) begin
            if (wb.wbm_stb_o) n_stb++;
            if (error) break;
            @(negedge clk);
        end
        checks++; if (error !== 1'b1 || n_stb != 255) begin errors++; $display("FAIL tmo_error: error %b stb cycles %0d expected 1 and 255", error, n_stb); end
        checks++; if (wb.wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_bus_idle: got cyc %b expected 0", wb.wbm_cyc_o); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL tmo_busy: busy %b dones %0d expected 0 and 0", busy, done_cnt - d0); end
        never_ack = 1'b0;
        begin_job();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL tmo_clear_on_start: got %b expected 0", error); end
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_recover_done: got %0d expected 1", ok); end
`else
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_tied: got %b expected 0", error); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_ack();
        test_reset_mid_job();
        test_start_while_busy();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
